duty_cycle_meter_mc: RTL and testbench

Multi-channel, parametrised duty-cycle and edge meter. This is the next generation of the single-channel 0.5 Hz-gated duty meter.
- Counts, per channel, the sys_clk cycles each input spends high and low, plus rising edges, over a runtime-programmable gate window.
- Publishes all channels atomically through a valid/ready result port.
- Sits between the external signal pins and the measurement/readout logic.
- Adds gap-free back-to-back windows, saturation, overflow flags and overrun detection.

---
 rtl/duty_meter_pkg.sv | 15 +
 rtl/duty_ch_counter.sv | 79 +++++++
 rtl/duty_cycle_meter_mc.sv | 147 ++++++++++++++
 tb/tb_duty_cycle_meter_mc.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duty_meter_pkg.sv
// rtl/duty_meter_pkg.sv - shared types and constants for the duty-cycle meter
package duty_meter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int MIN_GATE        = 2;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_GATE_W      = 32;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/duty_ch_counter.sv
// rtl/duty_ch_counter.sv - per-channel synchroniser, edge detector and saturating counters
module duty_ch_counter
    import duty_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             i_sig,
    input  logic             i_clear,
    input  logic             i_count_en,
    output logic [CNT_W-1:0] o_high_nxt,
    output logic [CNT_W-1:0] o_low_nxt,
    output logic [CNT_W-1:0] o_edge_nxt,
    output logic             o_ovf_nxt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [CNT_W-1:0]       r_high;
    logic [CNT_W-1:0]       r_low;
    logic [CNT_W-1:0]       r_edge;
    logic                   r_ovf;

    logic w_s;
    logic w_rise;
    logic w_inc_high;
    logic w_inc_low;
    logic w_inc_edge;
    logic w_sat;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;

    // Synchroniser chain and edge history run continuously, even outside a window
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_s_d  <= w_s;
        end
    end

    // Counts including this cycle's increment; the top publishes these at window end
    always_comb begin
        w_inc_high = i_count_en & w_s;
        w_inc_low  = i_count_en & ~w_s;
        w_inc_edge = i_count_en & w_rise;
        o_high_nxt = (w_inc_high && !(&r_high)) ? r_high + CNT_W'(1) : r_high;
        o_low_nxt  = (w_inc_low  && !(&r_low))  ? r_low  + CNT_W'(1) : r_low;
        o_edge_nxt = (w_inc_edge && !(&r_edge)) ? r_edge + CNT_W'(1) : r_edge;
        w_sat      = (w_inc_high & (&r_high)) | (w_inc_low & (&r_low)) | (w_inc_edge & (&r_edge));
        o_ovf_nxt  = r_ovf | w_sat;
    end

    // Counter state: clear has priority so the window-end cycle restarts from zero
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high <= '0;
            r_low  <= '0;
            r_edge <= '0;
            r_ovf  <= 1'b0;
        end else if (i_clear) begin
            r_high <= '0;
            r_low  <= '0;
            r_edge <= '0;
            r_ovf  <= 1'b0;
        end else if (i_count_en) begin
            r_high <= o_high_nxt;
            r_low  <= o_low_nxt;
            r_edge <= o_edge_nxt;
            r_ovf  <= o_ovf_nxt;
        end
    end

endmodule

// File: rtl/duty_cycle_meter_mc.sv
// rtl/duty_cycle_meter_mc.sv - multi-channel gated duty-cycle and edge meter
module duty_cycle_meter_mc
    import duty_meter_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int GATE_W      = DEF_GATE_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [GATE_W-1:0]       gate_len,
    input  logic [NUM_CH-1:0]       sig_in,
    output logic [NUM_CH*CNT_W-1:0] high_cnt,
    output logic [NUM_CH*CNT_W-1:0] low_cnt,
    output logic [NUM_CH*CNT_W-1:0] edge_cnt,
    output logic [NUM_CH-1:0]       cnt_ovf,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    result_overrun,
    output logic                    busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [GATE_W-1:0]   r_gl;
    logic [GATE_W-1:0]   r_wcnt;
    logic [GATE_W-1:0]   w_gl_in;
    logic                w_win_end;
    logic                w_clear;
    logic                w_latch;
    logic                w_count_en;

    logic [NUM_CH*CNT_W-1:0] w_high_nxt;
    logic [NUM_CH*CNT_W-1:0] w_low_nxt;
    logic [NUM_CH*CNT_W-1:0] w_edge_nxt;
    logic [NUM_CH-1:0]       w_ovf_nxt;

    logic [NUM_CH*CNT_W-1:0] r_high_cnt;
    logic [NUM_CH*CNT_W-1:0] r_low_cnt;
    logic [NUM_CH*CNT_W-1:0] r_edge_cnt;
    logic [NUM_CH-1:0]       r_cnt_ovf;
    logic                    r_valid;
    logic                    r_overrun;

    // Windows shorter than MIN_GATE are stretched so a window always has an end cycle
    assign w_gl_in = (gate_len < GATE_W'(MIN_GATE)) ? GATE_W'(MIN_GATE) : gate_len;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            duty_ch_counter #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_ch (
                .sys_clk    (sys_clk),
                .rst_n      (rst_n),
                .i_sig      (sig_in[gi]),
                .i_clear    (w_clear),
                .i_count_en (w_count_en),
                .o_high_nxt (w_high_nxt[gi*CNT_W +: CNT_W]),
                .o_low_nxt  (w_low_nxt[gi*CNT_W +: CNT_W]),
                .o_edge_nxt (w_edge_nxt[gi*CNT_W +: CNT_W]),
                .o_ovf_nxt  (w_ovf_nxt[gi])
            );
        end
    endgenerate

    // FSM state register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and window control; a window end with enable high chains straight into the next
    always_comb begin
        w_state_nxt = r_state;
        w_win_end   = 1'b0;
        w_clear     = 1'b0;
        w_latch     = 1'b0;
        w_count_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = MEASURE;
                    w_clear     = 1'b1;
                    w_latch     = 1'b1;
                end
            end
            MEASURE: begin
                w_count_en = 1'b1;
                if (r_wcnt == r_gl - GATE_W'(1)) begin
                    w_win_end = 1'b1;
                    w_clear   = 1'b1;
                    if (enable) w_latch     = 1'b1;
                    else        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Window length latch and window cycle counter
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gl   <= GATE_W'(MIN_GATE);
            r_wcnt <= '0;
        end else begin
            if (w_latch) r_gl <= w_gl_in;
            if (w_clear)         r_wcnt <= '0;
            else if (w_count_en) r_wcnt <= r_wcnt + GATE_W'(1);
        end
    end

    // Publish registers and result handshake; a new publish always overwrites pending data
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_high_cnt <= '0;
            r_low_cnt  <= '0;
            r_edge_cnt <= '0;
            r_cnt_ovf  <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_win_end) begin
            r_high_cnt <= w_high_nxt;
            r_low_cnt  <= w_low_nxt;
            r_edge_cnt <= w_edge_nxt;
            r_cnt_ovf  <= w_ovf_nxt;
            r_valid    <= 1'b1;
            if (r_valid && !result_ready)     r_overrun <= 1'b1;
            else if (r_valid && result_ready) r_overrun <= 1'b0;
        end else if (r_valid && result_ready) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign high_cnt       = r_high_cnt;
    assign low_cnt        = r_low_cnt;
    assign edge_cnt       = r_edge_cnt;
    assign cnt_ovf        = r_cnt_ovf;
    assign result_valid   = r_valid;
    assign result_overrun = r_overrun;
    assign busy           = (r_state == MEASURE);

endmodule

// File: tb/tb_duty_cycle_meter_mc.sv
// tb/tb_duty_cycle_meter_mc.sv - directed self-checking bench for duty_cycle_meter_mc
module tb_duty_cycle_meter_mc;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] gate_len;
    logic [1:0]  sig_in;
    logic        rready;

    logic [31:0] h16, l16, e16;
    logic [1:0]  ovf16;
    logic        valid16, ovr16, busy16;
    logic [15:0] h8, l8, e8;
    logic [1:0]  ovf8;
    logic        valid8, ovr8, busy8;

    int checks;
    int errors;

    duty_cycle_meter_mc #(.NUM_CH(2), .CNT_W(16), .GATE_W(32), .SYNC_STAGES(2)) dut16 (
        .sys_clk(clk), .rst_n(rst_n), .enable(enable), .gate_len(gate_len), .sig_in(sig_in),
        .high_cnt(h16), .low_cnt(l16), .edge_cnt(e16), .cnt_ovf(ovf16),
        .result_valid(valid16), .result_ready(rready), .result_overrun(ovr16), .busy(busy16)
    );

    duty_cycle_meter_mc #(.NUM_CH(2), .CNT_W(8), .GATE_W(32), .SYNC_STAGES(2)) dut8 (
        .sys_clk(clk), .rst_n(rst_n), .enable(enable), .gate_len(gate_len), .sig_in(sig_in),
        .high_cnt(h8), .low_cnt(l8), .edge_cnt(e8), .cnt_ovf(ovf8),
        .result_valid(valid8), .result_ready(rready), .result_overrun(ovr8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ch0 tied high, ch1 a 25% duty wave of period 20 (5 high, 15 low)
    initial begin
        int phase;
        phase = 0;
        sig_in = 2'b01;
        forever begin
            @(negedge clk);
            phase = (phase == 19) ? 0 : phase + 1;
            sig_in[1] = (phase < 5);
        end
    end

    task automatic wait_valid(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid16 && n < budget);
        checks++;
        if (valid16 !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid timeout: result_valid=%b after %0d cycles, required 1", valid16, n);
        end
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy16 && n < budget);
        checks++;
        if (busy16 !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle timeout: busy=%b after %0d cycles, required 0", busy16, n);
        end
    endtask

    task automatic drain();
        rready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; gate_len = 32'd100; rready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({h16, l16, e16, ovf16, valid16, ovr16, busy16} !== '0) begin
            errors++;
            $display("FAIL reset16: h=%h l=%h e=%h ovf=%b v=%b o=%b b=%b, required all 0", h16, l16, e16, ovf16, valid16, ovr16, busy16);
        end
        checks++;
        if ({h8, l8, e8, ovf8, valid8, ovr8, busy8} !== '0) begin
            errors++;
            $display("FAIL reset8: h=%h l=%h e=%h ovf=%b v=%b o=%b b=%b, required all 0", h8, l8, e8, ovf8, valid8, ovr8, busy8);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        gate_len = 32'd100; rready = 1'b1; enable = 1'b1;
        wait_valid(300, n);
        checks++;
        if (h16[15:0] !== 16'd100 || l16[15:0] !== 16'd0 || e16[15:0] !== 16'd0) begin
            errors++;
            $display("FAIL basic ch0: h=%0d l=%0d e=%0d, required 100 0 0", h16[15:0], l16[15:0], e16[15:0]);
        end
        checks++;
        if (h16[31:16] !== 16'd25 || l16[31:16] !== 16'd75 || e16[31:16] !== 16'd5) begin
            errors++;
            $display("FAIL basic ch1: h=%0d l=%0d e=%0d, required 25 75 5", h16[31:16], l16[31:16], e16[31:16]);
        end
        checks++;
        if (ovf16 !== 2'b00 || ovr16 !== 1'b0) begin
            errors++;
            $display("FAIL basic flags: ovf=%b overrun=%b, required 00 0", ovf16, ovr16);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic busy_dropped;
        logic pulse_long;
        for (int w = 0; w < 3; w++) begin
            busy_dropped = 1'b0;
            pulse_long = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (n == 1 && valid16) pulse_long = 1'b1;
                if (!busy16) busy_dropped = 1'b1;
            end while (!valid16 && n < 150);
            checks++;
            if (n !== 100 || pulse_long || busy_dropped) begin
                errors++;
                $display("FAIL b2b period w%0d: interval=%0d long=%b busy_dropped=%b, required 100 0 0", w, n, pulse_long, busy_dropped);
            end
            checks++;
            if (h16[15:0] + l16[15:0] !== 16'd100 || h16[31:16] + l16[31:16] !== 16'd100) begin
                errors++;
                $display("FAIL b2b sum w%0d: ch0=%0d ch1=%0d, required 100 100", w, h16[15:0] + l16[15:0], h16[31:16] + l16[31:16]);
            end
            checks++;
            if (h16[31:16] !== 16'd25 || e16[31:16] !== 16'd5) begin
                errors++;
                $display("FAIL b2b ch1 w%0d: h=%0d e=%0d, required 25 5", w, h16[31:16], e16[31:16]);
            end
        end
        enable = 1'b0;
        wait_idle(150, n);
        drain();
    endtask

    task automatic test_saturation();
        int n;
        gate_len = 32'd300; rready = 1'b1; enable = 1'b1;
        @(negedge clk);
        gate_len = 32'd200;
        wait_valid(400, n);
        checks++;
        if (h8[7:0] !== 8'd255 || l8[7:0] !== 8'd0 || ovf8 !== 2'b01) begin
            errors++;
            $display("FAIL sat8 win1: h=%0d l=%0d ovf=%b, required 255 0 01", h8[7:0], l8[7:0], ovf8);
        end
        checks++;
        if (h16[15:0] !== 16'd300 || ovf16 !== 2'b00) begin
            errors++;
            $display("FAIL sat16 win1: h=%0d ovf=%b, required 300 00", h16[15:0], ovf16);
        end
        enable = 1'b0;
        wait_valid(300, n);
        checks++;
        if (h8[7:0] !== 8'd200 || ovf8 !== 2'b00 || h8[15:8] + l8[15:8] !== 8'd200) begin
            errors++;
            $display("FAIL sat8 win2: h=%0d ovf=%b ch1sum=%0d, required 200 00 200", h8[7:0], ovf8, h8[15:8] + l8[15:8]);
        end
        wait_idle(10, n);
        drain();
    endtask

    task automatic test_overrun();
        int n;
        gate_len = 32'd10; rready = 1'b0; enable = 1'b1;
        @(negedge clk);
        gate_len = 32'd20;
        wait_valid(50, n);
        checks++;
        if (h16[15:0] !== 16'd10 || ovr16 !== 1'b0) begin
            errors++;
            $display("FAIL ovr first: h=%0d overrun=%b, required 10 0", h16[15:0], ovr16);
        end
        enable = 1'b0;
        wait_idle(50, n);
        checks++;
        if (h16[15:0] !== 16'd20 || l16[15:0] !== 16'd0 || ovr16 !== 1'b1 || valid16 !== 1'b1) begin
            errors++;
            $display("FAIL ovr second: h=%0d l=%0d overrun=%b valid=%b, required 20 0 1 1", h16[15:0], l16[15:0], ovr16, valid16);
        end
        rready = 1'b1;
        @(negedge clk);
        checks++;
        if (valid16 !== 1'b0 || ovr16 !== 1'b0) begin
            errors++;
            $display("FAIL ovr accept: valid=%b overrun=%b, required 0 0", valid16, ovr16);
        end
        drain();
    endtask

    task automatic test_enable_drop();
        int n;
        logic [31:0] gates [2];
        gate_len = 32'd100; rready = 1'b1; enable = 1'b1;
        repeat (40) @(negedge clk);
        enable = 1'b0;
        wait_idle(200, n);
        checks++;
        if (n + 40 !== 101 || valid16 !== 1'b1) begin
            errors++;
            $display("FAIL drop timing: cycles=%0d valid=%b, required 101 1", n + 40, valid16);
        end
        checks++;
        if (h16[15:0] !== 16'd100 || h16[31:16] !== 16'd25 || l16[31:16] !== 16'd75 || e16[31:16] !== 16'd5) begin
            errors++;
            $display("FAIL drop data: h0=%0d h1=%0d l1=%0d e1=%0d, required 100 25 75 5", h16[15:0], h16[31:16], l16[31:16], e16[31:16]);
        end
        drain();
        gates[0] = 32'd0;
        gates[1] = 32'd1;
        for (int g = 0; g < 2; g++) begin
            gate_len = gates[g]; enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
            wait_valid(20, n);
            checks++;
            if (n !== 2 || h16[15:0] !== 16'd2 || l16[15:0] !== 16'd0 || h16[31:16] + l16[31:16] !== 16'd2 || busy16 !== 1'b0) begin
                errors++;
                $display("FAIL short gate=%0d: lat=%0d h0=%0d l0=%0d sum1=%0d busy=%b, required 2 2 0 2 0", gates[g], n, h16[15:0], l16[15:0], h16[31:16] + l16[31:16], busy16);
            end
            drain();
        end
    endtask

    task automatic test_reset_mid_window();
        int n;
        logic early;
        gate_len = 32'd100; rready = 1'b1; enable = 1'b1;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({h16, l16, e16, ovf16, valid16, ovr16, busy16} !== '0 || {h8, l8, e8, ovf8, valid8, ovr8, busy8} !== '0) begin
            errors++;
            $display("FAIL midreset: h16=%h l16=%h busy=%b h8=%h busy8=%b, required all 0", h16, l16, busy16, h8, busy8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        early = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (valid16 || valid8) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL midreset early valid: seen=%b, required 0", early);
        end
        wait_valid(3, n);
        checks++;
        if (n !== 1 || h16[15:0] !== 16'd99 || l16[15:0] !== 16'd1 || e16[15:0] !== 16'd1 || h16[31:16] + l16[31:16] !== 16'd100) begin
            errors++;
            $display("FAIL midreset window: lat=%0d h0=%0d l0=%0d e0=%0d sum1=%0d, required 1 99 1 1 100", n, h16[15:0], l16[15:0], e16[15:0], h16[31:16] + l16[31:16]);
        end
        enable = 1'b0;
        wait_idle(200, n);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_overrun();
        test_enable_drop();
        test_reset_mid_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
